module_pulse_period_meter: RTL and testbench

// - Measures the spacing, in clk_10Mhz_i cycles, between consecutive rising edges of pulse_i.
// - Receiving end of the clock-divider tick: a tick-stream checker and a period/frequency readout for the labs.
// - Each measured period is presented on a valid/ready output; a timeout flags a stalled or absent pulse source.

---
 rtl/pkg_period_meter.sv | 8 +
 rtl/module_sync_edge.sv | 39 +++
 rtl/module_pulse_period_meter.sv | 152 +++++++++++++++
 tb/tb_module_pulse_period_meter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pkg_period_meter.sv
// Shared types and constants for the pulse period meter.
package pkg_period_meter;

  typedef enum logic {IDLE, MEASURE} state_e;

  localparam int unsigned CLK_HZ = 10_000_000;

endpackage

// File: rtl/module_sync_edge.sv
// Synchronizer for an asynchronous input followed by a registered
// rising-edge strobe. The strobe goes high SYNC_STAGES+1 cycles after the
// input rises and stays high for exactly one cycle.
module module_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   strobe_q, strobe_d;

  // Shift the input through the chain; remember the last synced level.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d   = sync_q[SYNC_STAGES-1];
    strobe_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Chain, edge history and strobe registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      strobe_q <= strobe_d;
    end
  end

  assign rise_o = strobe_q;

endmodule

// File: rtl/module_pulse_period_meter.sv
// Pulse period meter: counts clk_10Mhz_i cycles between rising edges of
// pulse_i and presents each period on a valid/ready output. A stalled
// source raises timeout_o. Define PERIOD_METER_MINMAX_EN to add min/max
// period tracking (clear_stats_i, min_o, max_o).
module module_pulse_period_meter
  import pkg_period_meter::*;
#(
  parameter int          CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2 * CLK_HZ,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic             clk_10Mhz_i,
  input  logic             reset_i,
  input  logic             pulse_i,
  input  logic             pausa_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             overrun_o
`ifdef PERIOD_METER_MINMAX_EN
  ,
  input  logic             clear_stats_i,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o
`endif
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             strobe;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             res_vld;
  logic [CNT_W-1:0] res_val;

  module_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk_i  (clk_10Mhz_i),
    .rst_i  (reset_i),
    .d_i    (pulse_i),
    .rise_o (strobe)
  );

  // Measurement FSM plus the output handshake for new results.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    res_vld   = 1'b0;
    res_val   = cnt_q + CNT_W'(1);

    // Pause freezes state and count and swallows strobes.
    if (!pausa_i) begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (strobe) state_d = MEASURE;
        end
        MEASURE: begin
          if (strobe) begin
            // A strobe on the timeout cycle still counts as a valid period.
            res_vld = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = res_val;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Keep an unconsumed result; a new one replaces it only if it leaves now.
    if (res_vld) begin
      if (!valid_q || ready_i) begin
        period_d = res_val;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Core state registers.
  always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;
  assign overrun_o = overrun_q;

`ifdef PERIOD_METER_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Track extremes of every produced result, kept or dropped; clear wins.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear_stats_i) begin
      min_d = '1;
      max_d = '0;
    end else if (res_vld) begin
      if (res_val < min_q) min_d = res_val;
      if (res_val > max_q) max_d = res_val;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
    if (reset_i) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`endif

endmodule

// File: tb/tb_module_pulse_period_meter.sv
// Directed bench for module_pulse_period_meter (TIMEOUT_CYCLES=100).
// Inputs change 1 time unit after the rising clock edge; outputs are
// observed on the falling edge by a monitor that logs transfers and pulses.
`timescale 1ns/1ps
module tb_module_pulse_period_meter;

  localparam int CNT_W = 32;

  logic             clk;
  logic             reset_i, pulse_i, pausa_i, ready_i;
  logic [CNT_W-1:0] period_o;
  logic             valid_o, timeout_o, overrun_o;
`ifdef PERIOD_METER_MINMAX_EN
  logic             clear_stats_i;
  logic [CNT_W-1:0] min_o, max_o;
`endif

  module_pulse_period_meter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (100),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_10Mhz_i (clk),
    .reset_i     (reset_i),
    .pulse_i     (pulse_i),
    .pausa_i     (pausa_i),
    .ready_i     (ready_i),
    .period_o    (period_o),
    .valid_o     (valid_o),
    .timeout_o   (timeout_o),
    .overrun_o   (overrun_o)
`ifdef PERIOD_METER_MINMAX_EN
    ,
    .clear_stats_i (clear_stats_i),
    .min_o         (min_o),
    .max_o         (max_o)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Monitor state
  int               cyc;
  int               n_to, to_cyc, res_cyc, n_ovr;
  logic [CNT_W-1:0] per_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      per_q.push_back(period_o);
      res_cyc <= cyc;
    end
    if (timeout_o) begin
      n_to   <= n_to + 1;
      to_cyc <= cyc;
    end
    if (overrun_o) n_ovr <= n_ovr + 1;
  end

  int n_chk, n_err;
  int b_x, b_to, b_ovr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One rising edge on pulse_i, next edge n cycles later.
  task automatic edge_gap(input int n);
    pulse_i = 1'b1;
    wait_cyc(1);
    pulse_i = 1'b0;
    wait_cyc(n - 1);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    pulse_i = 1'b0;
    pausa_i = 1'b0;
    wait_cyc(2);
    reset_i = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    cyc = 0; n_to = 0; to_cyc = 0; res_cyc = 0; n_ovr = 0;
    n_chk = 0; n_err = 0;
    reset_i = 1'b0; pulse_i = 1'b0; pausa_i = 1'b0; ready_i = 1'b1;
`ifdef PERIOD_METER_MINMAX_EN
    clear_stats_i = 1'b0;
`endif
    #5 reset_i = 1'b1;
    #1;
    check("rst_period",  period_o,  0);
    check("rst_valid",   valid_o,   0);
    check("rst_timeout", timeout_o, 0);
    check("rst_overrun", overrun_o, 0);
`ifdef PERIOD_METER_MINMAX_EN
    check("rst_min", min_o, 32'hFFFF_FFFF);
    check("rst_max", max_o, 0);
`endif

    // Divider-by-10 tick stream: 5 edges -> 4 periods of 10
    do_reset();
    ready_i = 1'b1;
    b_x = per_q.size(); b_to = n_to;
    repeat (5) edge_gap(10);
    check("div_count", per_q.size() - b_x, 4);
    for (int i = b_x; i < per_q.size(); i++) check("div_period", per_q[i], 10);

    // Source stops: timeout 100 cycles after the last result
    wait_cyc(100);
    check("to_count", n_to - b_to, 1);
    check("to_delay", to_cyc - res_cyc, 100);

    // Back in IDLE: first edge gives nothing, second gives the period
    b_x = per_q.size();
    edge_gap(12);
    check("idle_first_edge", per_q.size() - b_x, 0);
    edge_gap(12);
    check("idle_second_cnt", per_q.size() - b_x, 1);
    check("idle_second_per", per_q[per_q.size()-1], 12);

    // Back-pressure: 10 kept, 12 dropped with one overrun pulse
    do_reset();
    ready_i = 1'b0;
    b_ovr = n_ovr;
    edge_gap(10);
    edge_gap(12);
    edge_gap(10);
    check("ovr_period", period_o, 10);
    check("ovr_valid",  valid_o,  1);
    check("ovr_pulses", n_ovr - b_ovr, 1);
    ready_i = 1'b1;
    wait_cyc(1);
    check("ovr_drain_valid",  valid_o,  0);
    check("ovr_drain_period", period_o, 10);

    // Pause for 5 cycles inside a 25-cycle gap -> 20
    do_reset();
    ready_i = 1'b1;
    b_x = per_q.size();
    pulse_i = 1'b1;
    wait_cyc(1);
    pulse_i = 1'b0;
    wait_cyc(9);
    pausa_i = 1'b1;
    wait_cyc(5);
    pausa_i = 1'b0;
    wait_cyc(10);
    edge_gap(10);
    check("pause_cnt", per_q.size() - b_x, 1);
    check("pause_per", per_q[per_q.size()-1], 20);

    // Asynchronous reset mid-MEASURE
    do_reset();
    ready_i = 1'b0;
    edge_gap(10);
    edge_gap(10);
    check("pre_rst_valid", valid_o, 1);
    check("pre_rst_per",   period_o, 10);
    #20 reset_i = 1'b1;
    #5;
    check("async_rst_valid",   valid_o,   0);
    check("async_rst_period",  period_o,  0);
    check("async_rst_timeout", timeout_o, 0);
    wait_cyc(2);
    reset_i = 1'b0;
    wait_cyc(2);
    edge_gap(10);
    check("post_rst_first", valid_o, 0);
    edge_gap(10);
    check("post_rst_valid", valid_o, 1);
    check("post_rst_per",   period_o, 10);

`ifdef PERIOD_METER_MINMAX_EN
    // Min/max over periods 10, 12, 8 then clear
    do_reset();
    ready_i = 1'b1;
    edge_gap(10);
    edge_gap(12);
    edge_gap(8);
    edge_gap(10);
    check("mm_min", min_o, 8);
    check("mm_max", max_o, 12);
    clear_stats_i = 1'b1;
    wait_cyc(1);
    clear_stats_i = 1'b0;
    check("mm_clr_min", min_o, 32'hFFFF_FFFF);
    check("mm_clr_max", max_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
